rc_lagrange_up34: RTL

//  Rational 3:4 up-converter, the complement of the 4:3 sinc down-converter.

---
 rtl/rc_lagrange_up34_if.sv | 22 ++
 rtl/rc_lagrange_up34.sv | 87 ++++++++
 2 files changed

// File: rtl/rc_lagrange_up34_if.sv
// rtl/rc_lagrange_up34_if.sv - sample/observation bundle for the 3:4 Lagrange up-converter
interface rc_lagrange_up34_if;
  logic signed [7:0] x_in;
  logic [3:0]        count_o;
  logic              ena_in_o;
  logic              y_valid_o;
  logic signed [8:0] f0_o;
  logic signed [8:0] f1_o;
  logic signed [8:0] f2_o;
  logic signed [8:0] f3_o;
  logic signed [8:0] y_out;

  modport master (
    output x_in,
    input  count_o, ena_in_o, y_valid_o, f0_o, f1_o, f2_o, f3_o, y_out
  );

  modport slave (
    input  x_in,
    output count_o, ena_in_o, y_valid_o, f0_o, f1_o, f2_o, f3_o, y_out
  );
endinterface

// File: rtl/rc_lagrange_up34.sv
// rtl/rc_lagrange_up34.sv - rational 3:4 up-converter, 6-tap line feeding 4 cubic-Lagrange phases
module rc_lagrange_up34 #(
  parameter int IL = 2,
  parameter int OL = 3,
  parameter int L  = 5
) (
  input logic              clk,
  input logic              reset,
  rc_lagrange_up34_if.slave bus
);

  logic [3:0]        count;
  logic signed [7:0] ibuf [0:IL];
  logic signed [7:0] x    [0:L];
  logic signed [8:0] f    [0:3];
  logic signed [8:0] obuf [0:OL];

  logic ena_in, ena_x, ena_ld, ena_sh;

  assign ena_in = (count == 4'd0) || (count == 4'd4) || (count == 4'd8);
  assign ena_x  = (count == 4'd11);
  assign ena_ld = (count == 4'd1);
  assign ena_sh = (count == 4'd4) || (count == 4'd7) || (count == 4'd10);

  // Four-tap dot product: 17b products, 19b sum, floor shift, low 9 bits kept.
  function automatic logic signed [8:0] fir4(
    input logic signed [7:0] a, input logic signed [7:0] b,
    input logic signed [7:0] c, input logic signed [7:0] d,
    input logic signed [8:0] ca, input logic signed [8:0] cb,
    input logic signed [8:0] cc, input logic signed [8:0] cd
  );
    logic signed [16:0] pa, pb, pc, pd;
    logic signed [18:0] acc;
    pa  = a * ca;
    pb  = b * cb;
    pc  = c * cc;
    pd  = d * cd;
    acc = {{2{pa[16]}}, pa} + {{2{pb[16]}}, pb} + {{2{pc[16]}}, pc} + {{2{pd[16]}}, pd};
    return 9'(acc >>> 8);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
      for (int i = 0; i <= IL; i++) ibuf[i] <= '0;
      for (int i = 0; i <= L; i++)  x[i]    <= '0;
      for (int i = 0; i < 4; i++)   f[i]    <= '0;
      for (int i = 0; i <= OL; i++) obuf[i] <= '0;
    end else begin
      count <= (count == 4'd11) ? 4'd0 : count + 4'd1;

      if (ena_in) begin
        ibuf[0] <= bus.x_in;
        for (int i = 1; i <= IL; i++) ibuf[i] <= ibuf[i-1];
      end

      if (ena_x) begin
        for (int i = 0; i <= IL; i++) begin
          x[i]        <= ibuf[i];
          x[i+IL+1]   <= x[i];
        end
      end

      // x[5] is the oldest tap; phases sit at t = 1.00, 1.75, 2.50, 3.25.
      f[0] <= {x[4][7], x[4]};
      f[1] <= fir4(x[5], x[4], x[3], x[2], -9'sd10, 9'sd70, 9'sd210, -9'sd14);
      f[2] <= fir4(x[4], x[3], x[2], x[1], -9'sd16, 9'sd144, 9'sd144, -9'sd16);
      f[3] <= fir4(x[3], x[2], x[1], x[0], -9'sd14, 9'sd210, 9'sd70, -9'sd10);

      if (ena_ld) begin
        for (int i = 0; i <= OL; i++) obuf[i] <= f[i];
      end else if (ena_sh) begin
        for (int i = 0; i < OL; i++) obuf[i] <= obuf[i+1];
      end
    end
  end

  assign bus.count_o   = count;
  assign bus.ena_in_o  = ena_in;
  assign bus.y_valid_o = (count == 4'd2) || (count == 4'd5) || (count == 4'd8) || (count == 4'd11);
  assign bus.f0_o      = f[0];
  assign bus.f1_o      = f[1];
  assign bus.f2_o      = f[2];
  assign bus.f3_o      = f[3];
  assign bus.y_out     = obuf[0];

endmodule
